// File: rtl/apb_rsp_pkg.sv
// apb_rsp_pkg: shared FSM state encoding and address decode helper for apb_reg_responder
package apb_rsp_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t WAIT  = 2'd1;
  localparam state_t READY = 2'd2;
  typedef struct packed {
    logic        in_range;
    logic        aligned;
    logic [31:0] idx;
  } dec_t;
  function automatic dec_t decode(input logic [63:0] addr, input logic [63:0] base,
                                  input int unsigned nregs, input int unsigned bytes,
                                  input int unsigned lsb);
    dec_t d;
    logic [63:0] off;
    off = addr - base;
    d.in_range = (addr >= base) && (off < 64'(nregs) * 64'(bytes));
    d.aligned  = (addr & (64'(bytes) - 64'd1)) == 64'd0;
    d.idx      = 32'(off >> lsb);
    return d;
  endfunction
endpackage

// File: rtl/apb_reg_responder_if.sv
// apb_reg_responder_if: APB bus signals seen from the completer side
interface apb_reg_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                    psel_i;
  logic                    penable_i;
  logic [ADDR_WIDTH-1:0]   paddr_i;
  logic                    pwrite_i;
  logic [DATA_WIDTH-1:0]   pwdata_i;
  logic [DATA_WIDTH/8-1:0] pstrb_i;
  logic                    pready_o;
  logic [DATA_WIDTH-1:0]   prdata_o;
  logic                    pslverr_o;
  modport slave (
    input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i, pstrb_i,
    output pready_o, prdata_o, pslverr_o
  );
  modport master (
    output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i, pstrb_i,
    input  pready_o, prdata_o, pslverr_o
  );
endinterface

// File: rtl/apb_rsp_regfile.sv
// apb_rsp_regfile: register bank with byte-strobe merge and per-register write pulse
module apb_rsp_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int IW         = 3
) (
  input  logic                           clk_i,
  input  logic                           arst_ni,
  input  logic                           we_i,
  input  logic [IW-1:0]                  idx_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        strb_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q;
  // commit a strobed write and raise the pulse for exactly one cycle
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (we_i) begin
        for (int b = 0; b < DATA_WIDTH/8; b++)
          if (strb_i[b]) regs_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        wr_pulse_q[idx_i] <= 1'b1;
      end
    end
  end
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign regs_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
  end
  assign wr_pulse_o = wr_pulse_q;
endmodule

// File: rtl/apb_reg_responder.sv
// apb_reg_responder: APB completer over a register bank; wait states enabled by APB_RSP_WAIT_EN
module apb_reg_responder
  import apb_rsp_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 0
) (
  input  logic                           clk_i,
  input  logic                           arst_ni,
  apb_reg_responder_if.slave             bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = BYTES > 1 ? $clog2(BYTES) : 0;
  localparam int IW    = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  state_t                state_q, state_d;
  logic                  err_q, err_d, wr_q, wr_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, prdata_q, prdata_d;
  logic [BYTES-1:0]      strb_q, strb_d;
  logic                  pready_q, pready_d, pslverr_q, pslverr_d;
  logic                  commit, go_rdy, idle;
  logic                  cur_err, cur_wr;
  logic [IW-1:0]         cur_idx;
  logic [DATA_WIDTH-1:0] cur_rdata;
  dec_t                  dec_in;
`ifdef APB_RSP_WAIT_EN
  localparam logic [7:0] WC = 8'(WAIT_CYCLES);
  logic [7:0]            cnt_q, cnt_d;
`endif
  assign dec_in    = decode(64'(bus.paddr_i), 64'(BASE_ADDR), NUM_REGS, BYTES, LSB);
  assign idle      = state_q == IDLE;
  assign cur_err   = idle ? !(dec_in.in_range && dec_in.aligned) : err_q;
  assign cur_wr    = idle ? bus.pwrite_i : wr_q;
  assign cur_idx   = idle ? dec_in.idx[IW-1:0] : idx_q;
  assign cur_rdata = regs_o[cur_idx*DATA_WIDTH +: DATA_WIDTH];
  // handshake FSM: latch at setup, optional wait countdown, complete in READY
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    commit    = 1'b0;
    go_rdy    = 1'b0;
`ifdef APB_RSP_WAIT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: if (bus.psel_i && !bus.penable_i) begin
        err_d   = cur_err;
        wr_d    = bus.pwrite_i;
        idx_d   = dec_in.idx[IW-1:0];
        wdata_d = bus.pwdata_i;
        strb_d  = bus.pstrb_i;
`ifdef APB_RSP_WAIT_EN
        if (WC != 8'd0) begin
          state_d = WAIT;
          cnt_d   = WC;
        end else go_rdy = 1'b1;
`else
        go_rdy = 1'b1;
`endif
      end
`ifdef APB_RSP_WAIT_EN
      WAIT: if (!bus.psel_i) state_d = IDLE;
      else begin
        cnt_d  = cnt_q - 8'd1;
        go_rdy = cnt_q == 8'd1;
      end
`endif
      READY: if (!bus.psel_i) state_d = IDLE;
      else if (bus.penable_i) begin
        commit  = wr_q && !err_q;
        state_d = IDLE;
      end else begin
        pready_d  = 1'b1;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
      end
      default: state_d = IDLE;
    endcase
    if (go_rdy) begin
      state_d   = READY;
      pready_d  = 1'b1;
      pslverr_d = cur_err;
      prdata_d  = (!cur_wr && !cur_err) ? cur_rdata : '0;
    end
  end
  // state and registered outputs
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= IDLE;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
`ifdef APB_RSP_WAIT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      wr_q      <= wr_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
`ifdef APB_RSP_WAIT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end
  assign bus.pready_o  = pready_q;
  assign bus.pslverr_o = pslverr_q;
  assign bus.prdata_o  = prdata_q;
  apb_rsp_regfile #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .IW(IW)) u_regfile (
    .clk_i      (clk_i),
    .arst_ni    (arst_ni),
    .we_i       (commit),
    .idx_i      (idx_q),
    .wdata_i    (wdata_q),
    .strb_i     (strb_q),
    .regs_o     (regs_o),
    .wr_pulse_o (wr_pulse_o)
  );
endmodule

// File: tb/tb_apb_reg_responder.sv
// tb_apb_reg_responder: directed self-checking bench for apb_reg_responder
module tb_apb_reg_responder;
  localparam int          NR   = 8;
  localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef APB_RSP_WAIT_EN
  localparam int W = 3;
`else
  localparam int W = 0;
`endif
  logic            clk = 1'b0;
  logic            arst_n = 1'b0;
  logic [NR*32-1:0] regs;
  logic [NR-1:0]    wp;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  apb_reg_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  apb_reg_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR), .BASE_ADDR(BASE), .WAIT_CYCLES(3)
  ) dut (
    .clk_i      (clk),
    .arst_ni    (arst_n),
    .bus        (bus),
    .regs_o     (regs),
    .wr_pulse_o (wp)
  );
  task automatic idle(input int n);
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic er);
    int acc;
    bit got;
    bus.psel_i    = 1'b1;
    bus.penable_i = 1'b0;
    bus.paddr_i   = a;
    bus.pwrite_i  = w;
    bus.pwdata_i  = d;
    bus.pstrb_i   = s;
    @(posedge clk);
    #1 bus.penable_i = 1'b1;
    acc = 0;
    got = 0;
    rd  = 'x;
    er  = 'x;
    while (!got && acc < 40) begin
      @(negedge clk);
      acc++;
      if (bus.pready_o) begin
        rd  = bus.prdata_o;
        er  = bus.pslverr_o;
        got = 1;
      end else begin
        checks++;
        if (bus.prdata_o !== 32'h0) begin
          errors++;
          $display("FAIL prdata_idle addr=%h: got %h, expected 0", a, bus.prdata_o);
        end
      end
      @(posedge clk);
      #1;
    end
    bus.penable_i = 1'b0;
    checks++;
    if (!got || acc != W + 1) begin
      errors++;
      $display("FAIL xfer_len addr=%h: access cycles %0d (done=%0d), expected %0d", a, acc, got, W + 1);
    end
  endtask
  task automatic test_reset;
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
    bus.paddr_i   = '0;
    bus.pwrite_i  = 1'b0;
    bus.pwdata_i  = '0;
    bus.pstrb_i   = '0;
    arst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (bus.pready_o !== 1'b0) begin errors++; $display("FAIL reset_pready: got %b, expected 0", bus.pready_o); end
    if (bus.pslverr_o !== 1'b0) begin errors++; $display("FAIL reset_pslverr: got %b, expected 0", bus.pslverr_o); end
    if (bus.prdata_o !== 32'h0) begin errors++; $display("FAIL reset_prdata: got %h, expected 0", bus.prdata_o); end
    if (wp !== '0) begin errors++; $display("FAIL reset_wr_pulse: got %b, expected 0", wp); end
    for (int k = 0; k < NR; k++) begin
      checks++;
      if (regs[k*32 +: 32] !== 32'h0) begin errors++; $display("FAIL reset_reg%0d: got %h, expected 0", k, regs[k*32 +: 32]); end
    end
    arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_full_write;
    logic [31:0] rd;
    logic er;
    xfer(BASE + 32'd4, 1'b1, 32'hDEADBEEF, 4'hF, rd, er);
    checks += 2;
    if (er !== 1'b0) begin errors++; $display("FAIL fw_err: got %b, expected 0", er); end
    if (wp !== 8'b0000_0010) begin errors++; $display("FAIL fw_pulse: got %b, expected 00000010", wp); end
    idle(1);
    checks += 2;
    if (wp !== '0) begin errors++; $display("FAIL fw_pulse_end: got %b, expected 0", wp); end
    if (regs[32 +: 32] !== 32'hDEADBEEF) begin errors++; $display("FAIL fw_reg1: got %h, expected deadbeef", regs[32 +: 32]); end
    xfer(BASE + 32'd4, 1'b0, 32'h0, 4'h0, rd, er);
    checks += 3;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL fw_read: got %h, expected deadbeef", rd); end
    if (er !== 1'b0) begin errors++; $display("FAIL fw_read_err: got %b, expected 0", er); end
    if (wp !== '0) begin errors++; $display("FAIL fw_read_pulse: got %b, expected 0", wp); end
    idle(1);
  endtask
  task automatic test_strobe;
    logic [31:0] rd;
    logic er;
    xfer(BASE + 32'd8, 1'b1, 32'h11223344, 4'hF, rd, er);
    idle(1);
    xfer(BASE + 32'd8, 1'b1, 32'h0000AB00, 4'b0010, rd, er);
    idle(1);
    xfer(BASE + 32'd8, 1'b0, 32'h0, 4'hF, rd, er);
    checks++;
    if (rd !== 32'h1122AB44) begin errors++; $display("FAIL strb_read: got %h, expected 1122ab44", rd); end
    idle(1);
    xfer(BASE + 32'd8, 1'b1, 32'hFFFFFFFF, 4'h0, rd, er);
    checks += 2;
    if (er !== 1'b0) begin errors++; $display("FAIL strb0_err: got %b, expected 0", er); end
    if (wp !== 8'b0000_0100) begin errors++; $display("FAIL strb0_pulse: got %b, expected 00000100", wp); end
    idle(1);
    checks++;
    if (regs[64 +: 32] !== 32'h1122AB44) begin errors++; $display("FAIL strb0_reg2: got %h, expected 1122ab44", regs[64 +: 32]); end
  endtask
  task automatic test_errors;
    logic [31:0] rd;
    logic er;
    logic [NR*32-1:0] snap;
    logic [31:0] bad [4];
    bad[0] = BASE + 32'd32;
    bad[1] = BASE + 32'd2;
    bad[2] = BASE - 32'd4;
    bad[3] = BASE + 32'd31;
    snap = regs;
    for (int i = 0; i < 4; i++) begin
      xfer(bad[i], 1'b1, 32'hCAFEF00D, 4'hF, rd, er);
      checks += 2;
      if (er !== 1'b1) begin errors++; $display("FAIL err_wr%0d: pslverr %b, expected 1", i, er); end
      if (wp !== '0) begin errors++; $display("FAIL err_pulse%0d: got %b, expected 0", i, wp); end
      idle(1);
      checks++;
      if (regs !== snap) begin errors++; $display("FAIL err_regs%0d: registers changed", i); end
    end
    xfer(BASE + 32'd32, 1'b0, 32'h0, 4'h0, rd, er);
    checks += 2;
    if (er !== 1'b1) begin errors++; $display("FAIL err_rd: pslverr %b, expected 1", er); end
    if (rd !== 32'h0) begin errors++; $display("FAIL err_rd_data: got %h, expected 0", rd); end
    idle(1);
  endtask
  task automatic test_back_to_back;
    logic [31:0] rd;
    logic er;
    xfer(BASE + 32'd0, 1'b1, 32'hA5A5A5A5, 4'hF, rd, er);
    checks++;
    if (wp !== 8'b0000_0001) begin errors++; $display("FAIL b2b_pulse0: got %b, expected 00000001", wp); end
    xfer(BASE + 32'd4, 1'b0, 32'h0, 4'h0, rd, er);
    checks += 2;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_read1: got %h, expected deadbeef", rd); end
    if (er !== 1'b0) begin errors++; $display("FAIL b2b_read1_err: got %b, expected 0", er); end
    xfer(BASE + 32'd8, 1'b1, 32'h12345678, 4'hF, rd, er);
    checks++;
    if (wp !== 8'b0000_0100) begin errors++; $display("FAIL b2b_pulse2: got %b, expected 00000100", wp); end
    xfer(BASE + 32'd0, 1'b0, 32'h0, 4'h0, rd, er);
    checks++;
    if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_read0: got %h, expected a5a5a5a5", rd); end
    idle(1);
    checks += 2;
    if (regs[0 +: 32] !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_reg0: got %h, expected a5a5a5a5", regs[0 +: 32]); end
    if (regs[64 +: 32] !== 32'h12345678) begin errors++; $display("FAIL b2b_reg2: got %h, expected 12345678", regs[64 +: 32]); end
  endtask
  task automatic test_reset_mid;
    logic [31:0] rd;
    logic er;
    bus.psel_i    = 1'b1;
    bus.penable_i = 1'b0;
    bus.paddr_i   = BASE + 32'd12;
    bus.pwrite_i  = 1'b1;
    bus.pwdata_i  = 32'hFFFFFFFF;
    bus.pstrb_i   = 4'hF;
    @(posedge clk);
    #1 bus.penable_i = 1'b1;
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    checks += 4;
    if (bus.pready_o !== 1'b0) begin errors++; $display("FAIL rmid_pready: got %b, expected 0", bus.pready_o); end
    if (bus.prdata_o !== 32'h0) begin errors++; $display("FAIL rmid_prdata: got %h, expected 0", bus.prdata_o); end
    if (wp !== '0) begin errors++; $display("FAIL rmid_pulse: got %b, expected 0", wp); end
    if (regs !== '0) begin errors++; $display("FAIL rmid_regs: registers not cleared"); end
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    checks += 2;
    if (regs[96 +: 32] !== 32'h0) begin errors++; $display("FAIL rmid_reg3: got %h, expected 0", regs[96 +: 32]); end
    if (wp !== '0) begin errors++; $display("FAIL rmid_pulse_after: got %b, expected 0", wp); end
    xfer(BASE + 32'd12, 1'b1, 32'h0F0F0F0F, 4'hF, rd, er);
    checks++;
    if (wp !== 8'b0000_1000) begin errors++; $display("FAIL rmid_next_pulse: got %b, expected 00001000", wp); end
    xfer(BASE + 32'd12, 1'b0, 32'h0, 4'h0, rd, er);
    checks += 2;
    if (rd !== 32'h0F0F0F0F) begin errors++; $display("FAIL rmid_next_read: got %h, expected 0f0f0f0f", rd); end
    if (er !== 1'b0) begin errors++; $display("FAIL rmid_next_err: got %b, expected 0", er); end
    idle(1);
  endtask
  initial begin
    test_reset;
    test_full_write;
    test_strobe;
    test_errors;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
